// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: shared state encoding and default geometry for the set-associative icache.
package icache_sa_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2} state_t;
    localparam int DEF_SET_WIDTH       = 6;
    localparam int DEF_LINE_WORD_WIDTH = 2;
    localparam int DEF_WAY_WIDTH       = 1;
endpackage

// File: rtl/icache_sa_way.sv
// icache_sa_way: valid/tag/data storage for one way, two combinational lookup ports,
// one fill-word write port and a tag/valid install port.
module icache_sa_way #(
    parameter int SW = 6,
    parameter int LW = 2,
    parameter int TW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [SW-1:0] i_set_w,
    input  logic [LW-1:0] i_word_w,
    input  logic [31:0]   i_data_w,
    input  logic          i_tv_we,
    input  logic [TW-1:0] i_tag_w,
    input  logic [SW-1:0] i_set_a,
    input  logic [TW-1:0] i_tag_a,
    input  logic [LW-1:0] i_word_a,
    input  logic [SW-1:0] i_set_b,
    input  logic [TW-1:0] i_tag_b,
    input  logic [LW-1:0] i_word_b,
    output logic          o_hit_a,
    output logic [31:0]   o_data_a,
    output logic          o_hit_b,
    output logic [31:0]   o_data_b,
    output logic [(1<<SW)-1:0] o_valid
);
    logic [(1<<SW)-1:0] r_valid;
    logic [TW-1:0]      r_tag  [1<<SW];
    logic [31:0]        r_data [1<<(SW+LW)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_valid <= '0;
        else if (i_clr) r_valid <= '0;
        else if (i_tv_we) r_valid[i_set_w] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_tv_we) r_tag[i_set_w] <= i_tag_w;
        if (i_we) r_data[{i_set_w, i_word_w}] <= i_data_w;
    end

    assign o_hit_a  = r_valid[i_set_a] && r_tag[i_set_a] == i_tag_a;
    assign o_hit_b  = r_valid[i_set_b] && r_tag[i_set_b] == i_tag_b;
    assign o_data_a = r_data[{i_set_a, i_word_a}];
    assign o_data_b = r_data[{i_set_b, i_word_b}];
    assign o_valid  = r_valid;
endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with line refill FSM, straddling 32-bit
// fetches, fence.i flush and redirect abort.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int SET_WIDTH       = DEF_SET_WIDTH,
    parameter int LINE_WORD_WIDTH = DEF_LINE_WORD_WIDTH,
    parameter int WAY_WIDTH       = DEF_WAY_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        if_valid_in,
    input  logic [31:0] if_addr_in,
    input  logic        if_abort_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_busy_in,
    input  logic        mem_valid_in,
    input  logic [31:0] mem_data_in
);
    localparam int OFF       = LINE_WORD_WIDTH + 2;
    localparam int TAG_WIDTH = 32 - SET_WIDTH - OFF;
    localparam int NWAYS     = 1 << WAY_WIDTH;
    localparam int NSETS     = 1 << SET_WIDTH;
    localparam int VW        = WAY_WIDTH > 0 ? WAY_WIDTH : 1;

    state_t                     r_state, w_next;
    logic [SET_WIDTH-1:0]       r_set;
    logic [TAG_WIDTH-1:0]       r_tag;
    logic [VW-1:0]              r_way;
    logic [LINE_WORD_WIDTH-1:0] r_cnt;
    logic                       r_discard;
    logic [VW-1:0]              r_rr [NSETS];

    logic [31:0] w_addr_a, w_addr_b, w_t_addr, w_word_a, w_word_b;
    logic [15:0] w_hw_a, w_hw_b;
    logic [NWAYS-1:0] w_hit_a, w_hit_b;
    logic [31:0] w_data_a [NWAYS];
    logic [31:0] w_data_b [NWAYS];
    logic [NSETS-1:0] w_valid [NWAYS];
    logic w_any_a, w_any_b, w_cmp, w_hit, w_look, w_miss, w_fill_we, w_last, w_install, w_clr;
    logic [VW-1:0] w_victim;

    assign w_addr_a = {if_addr_in[31:1], 1'b0};
    assign w_addr_b = w_addr_a + 32'd2;
    assign w_fill_we = rdy_in && r_state == FILL && mem_valid_in;
    assign w_last    = &r_cnt;
    assign w_install = w_fill_we && w_last && !r_discard && !flush_in;
    assign w_clr     = rdy_in && flush_in;

    for (genvar g = 0; g < NWAYS; g++) begin : g_way
        icache_sa_way #(.SW(SET_WIDTH), .LW(LINE_WORD_WIDTH), .TW(TAG_WIDTH)) u_way (
            .clk(clk_in), .rst_n(rst_in), .i_clr(w_clr),
            .i_we(w_fill_we && r_way == VW'(g)), .i_set_w(r_set), .i_word_w(r_cnt),
            .i_data_w(mem_data_in), .i_tv_we(w_install && r_way == VW'(g)), .i_tag_w(r_tag),
            .i_set_a(w_addr_a[OFF+SET_WIDTH-1:OFF]), .i_tag_a(w_addr_a[31:OFF+SET_WIDTH]),
            .i_word_a(w_addr_a[OFF-1:2]),
            .i_set_b(w_addr_b[OFF+SET_WIDTH-1:OFF]), .i_tag_b(w_addr_b[31:OFF+SET_WIDTH]),
            .i_word_b(w_addr_b[OFF-1:2]),
            .o_hit_a(w_hit_a[g]), .o_data_a(w_data_a[g]), .o_hit_b(w_hit_b[g]),
            .o_data_b(w_data_b[g]), .o_valid(w_valid[g])
        );
    end

    // A line lives in at most one way, so an OR across hitting ways selects the data.
    always_comb begin
        w_word_a = '0;
        w_word_b = '0;
        for (int w = 0; w < NWAYS; w++) begin
            w_word_a = w_word_a | (w_hit_a[w] ? w_data_a[w] : 32'h0);
            w_word_b = w_word_b | (w_hit_b[w] ? w_data_b[w] : 32'h0);
        end
    end

    assign w_any_a = |w_hit_a;
    assign w_any_b = |w_hit_b;
    assign w_hw_a  = w_addr_a[1] ? w_word_a[31:16] : w_word_a[15:0];
    assign w_hw_b  = w_addr_b[1] ? w_word_b[31:16] : w_word_b[15:0];
    assign w_cmp   = w_hw_a[1:0] != 2'b11;
    assign w_hit   = w_any_a && (w_cmp || w_any_b);
    assign w_look  = r_state == IDLE && rdy_in && if_valid_in && !if_abort_in && !flush_in;
    assign w_miss  = w_look && !w_hit;
    assign instr_ready_out = w_look && w_hit;
    assign instr_out = !instr_ready_out ? 32'h0 : w_cmp ? {16'h0, w_hw_a} : {w_hw_b, w_hw_a};
    assign w_t_addr = w_any_a ? w_addr_b : w_addr_a;

    // Descending scan leaves the lowest invalid way; otherwise round-robin.
    always_comb begin
        w_victim = r_rr[w_t_addr[OFF+SET_WIDTH-1:OFF]];
        for (int w = NWAYS - 1; w >= 0; w--)
            if (!w_valid[w][w_t_addr[OFF+SET_WIDTH-1:OFF]]) w_victim = VW'(w);
    end

    always_comb begin
        w_next = r_state;
        if (rdy_in)
            w_next = (r_state == IDLE && w_miss) ? REQ :
                     (r_state == REQ && !mem_busy_in) ? FILL :
                     (w_fill_we && w_last) ? IDLE : r_state;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= IDLE;
            r_set     <= '0;
            r_tag     <= '0;
            r_way     <= '0;
            r_cnt     <= '0;
            r_discard <= 1'b0;
        end else if (rdy_in) begin
            r_state <= w_next;
            if (w_miss) begin
                r_set     <= w_t_addr[OFF+SET_WIDTH-1:OFF];
                r_tag     <= w_t_addr[31:OFF+SET_WIDTH];
                r_way     <= w_victim;
                r_discard <= 1'b0;
            end else if (flush_in && r_state != IDLE) r_discard <= 1'b1;
            if (r_state == REQ) r_cnt <= '0;
            else if (w_fill_we) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) for (int s = 0; s < NSETS; s++) r_rr[s] <= '0;
        else if (w_clr) for (int s = 0; s < NSETS; s++) r_rr[s] <= '0;
        else if (w_install) r_rr[r_set] <= (r_rr[r_set] == VW'(NWAYS - 1)) ? '0 : r_rr[r_set] + VW'(1);
    end

    assign mem_req_out  = r_state == REQ;
    assign mem_addr_out = {r_tag, r_set, {OFF{1'b0}}};
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: random and directed fetches against a line-presence model of a 64-set,
// 2-way, 16-byte-line cache backed by a fixed memory image.
module tb_icache_sa;
    logic        clk = 0, rst_n = 0, rdy = 1, flush = 0;
    logic        if_valid = 0, if_abort = 0, mem_busy = 0, mem_valid = 0;
    logic [31:0] if_addr = 0, mem_data = 0;
    logic        ready, mem_req;
    logic [31:0] instr, mem_addr;
    int checks = 0, failures = 0;

    bit          mv [64][2];
    logic [31:0] ml [64][2];
    int          fills [64];

    icache_sa dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .if_valid_in(if_valid), .if_addr_in(if_addr), .if_abort_in(if_abort),
        .instr_ready_out(ready), .instr_out(instr),
        .mem_req_out(mem_req), .mem_addr_out(mem_addr),
        .mem_busy_in(mem_busy), .mem_valid_in(mem_valid), .mem_data_in(mem_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if ((a >> 4) == 32'h100) return 32'h00000013;
        if (a == 32'h2000) return 32'h00014501;
        if (a == 32'h300C) return 32'h00B31234;
        if (a == 32'h3010) return 32'hABCD0000;
        w = a * 32'h9E3779B1;
        return w ^ (w >> 13);
    endfunction

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit present(input logic [31:0] line);
        for (int w = 0; w < 2; w++)
            if (mv[line % 64][w] && ml[line % 64][w] == line) return 1;
        return 0;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 0; mv[s][1] = 0; fills[s] = 0;
        end
    endfunction

    function automatic void model_install(input logic [31:0] line);
        int s, v;
        s = line % 64;
        v = !mv[s][0] ? 0 : !mv[s][1] ? 1 : fills[s] % 2;
        mv[s][v] = 1; ml[s][v] = line; fills[s]++;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Serves one line request already visible on mem_req; busy<0 picks a random stall.
    task automatic do_fill(input logic [31:0] line, input int flush_at, input int busy);
        int nb;
        nb = busy < 0 ? int'($urandom_range(0, 2)) : busy;
        for (int b = 0; b < nb; b++) begin
            mem_busy = 1;
            @(negedge clk);
            check("req_hold", mem_req, 1);
            check("busy_no_ready", ready, 0);
            tick();
        end
        mem_busy = 0;
        tick();
        check("req_dropped", mem_req, 0);
        for (int w = 0; w < 4; w++) begin
            repeat ($urandom_range(0, 1)) tick();
            mem_valid = 1;
            mem_data  = mem_word((line << 4) + 32'(4 * w));
            flush     = (w == flush_at);
            @(negedge clk);
            check("fill_no_ready", ready, 0);
            tick();
            mem_valid = 0; flush = 0;
        end
        if (flush_at >= 0) model_clear();
        else model_install(line);
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_first, input bit abort_req,
                         input int flush_at, input int busy);
        bit done;
        int fa;
        logic [31:0] la, lb, tl;
        logic [15:0] hwa;
        bit cmp, hit;
        done = 0; fa = flush_at;
        if_addr = a; if_valid = 1; if_abort = 0;
        for (int it = 0; it < 4 && !done; it++) begin
            @(negedge clk);
            la = a >> 4; lb = (a + 2) >> 4; hwa = mem_hw(a);
            cmp = hwa[1:0] != 2'b11;
            hit = present(la) && (cmp || present(lb));
            if (it == 0 && exp_first >= 0) check("first_lookup", ready, exp_first);
            check("ready", ready, hit);
            if (hit) begin
                check("instr", instr, cmp ? {16'h0, hwa} : {mem_hw(a + 2), hwa});
                done = 1;
                tick();
            end else begin
                tl = present(la) ? lb : la;
                tick();
                check("req", mem_req, 1);
                check("req_addr", mem_addr, tl << 4);
                if (abort_req) if_abort = 1;
                do_fill(tl, fa, busy);
                fa = -1;
                if (abort_req) done = 1;
            end
        end
        check("fetch_done", done, 1);
        if_valid = 0; if_abort = 0;
    endtask

    task automatic peek(input logic [31:0] a, input logic exp_ready, input logic [31:0] exp_instr);
        if_addr = a; if_valid = 1;
        @(negedge clk);
        check("peek_ready", ready, exp_ready);
        check("peek_instr", instr, exp_instr);
        tick();
        if_valid = 0;
    endtask

    task automatic flush_pulse();
        flush = 1;
        tick();
        flush = 0;
        model_clear();
    endtask

    initial begin
        logic [31:0] a;
        int s;
        model_clear();
        if_valid = 1; if_addr = 32'h1000;
        #12;
        check("rst_ready", ready, 0);
        check("rst_instr", instr, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        if_valid = 0;
        #1 rst_n = 1;
        tick();

        fetch(32'h1000, 0, 0, -1, -1);
        peek(32'h1000, 1, 32'h00000013);
        fetch(32'h1004, 1, 0, -1, -1);

        fetch(32'h2000, 0, 0, -1, -1);
        peek(32'h2000, 1, 32'h00004501);
        peek(32'h2002, 1, 32'h00000001);

        fetch(32'h300E, 0, 0, -1, -1);
        peek(32'h300E, 1, 32'h000000B3);

        flush_pulse();
        fetch(32'h1000, 0, 0, -1, -1);
        fetch(32'h1400, 0, 0, -1, -1);
        fetch(32'h1800, 0, 0, -1, -1);
        fetch(32'h1400, 1, 0, -1, -1);
        fetch(32'h1000, 0, 0, -1, -1);

        fetch(32'h4000, 0, 0, 2, -1);
        fetch(32'h4000, 1, 0, -1, -1);

        fetch(32'h5000, 0, 1, -1, 3);
        fetch(32'h5000, 1, 0, -1, -1);

        rdy = 0; if_valid = 1; if_addr = 32'h5000;
        @(negedge clk);
        check("rdy0_ready", ready, 0);
        if_addr = 32'h6000;
        tick(); tick();
        check("rdy0_no_req", mem_req, 0);
        if_valid = 0; rdy = 1;
        tick();

        if_valid = 1; if_addr = 32'h7000;
        tick();
        check("rst_test_req", mem_req, 1);
        tick();
        mem_valid = 1; mem_data = mem_word(32'h7000);
        tick(); tick();
        mem_valid = 0;
        #2 rst_n = 0;
        #1;
        check("midfill_rst_req", mem_req, 0);
        check("midfill_rst_ready", ready, 0);
        if_valid = 0;
        model_clear();
        tick();
        rst_n = 1;
        tick();
        fetch(32'h5000, 0, 0, -1, -1);

        for (int n = 0; n < 60; n++) begin
            s = $urandom_range(0, 2);
            s = s == 2 ? 63 : s;
            a = 32'h20000 + ($urandom_range(0, 3) << 10) + 32'(s << 4) + ($urandom_range(0, 7) << 1);
            fetch(a, -1, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 3)) : -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache. It replaces the direct-mapped halfword icache between the IF stage and the memory controller. Lines are multi-word, ways are configurable, and a refill state machine fetches a whole line with a word-wide burst handshake. It serves both 16-bit compressed and 32-bit instructions, including 32-bit instructions that straddle a line boundary. It also supports a full flush (fence.i) and fetch abort on redirect.

## Interface
Parameters:
- SET_WIDTH, 6, log2 of the number of sets.
- LINE_WORD_WIDTH, 2, log2 of the number of 32-bit words per line (4 words = 16 B).
- WAY_WIDTH, 1, log2 of the number of ways (0..2).
- Derived: TAG_WIDTH = 32 - SET_WIDTH - LINE_WORD_WIDTH - 2.

Ports:
- clk_in  in  1  single clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush_in  in  1  invalidate every line.
- if_valid_in  in  1  fetch request valid (level, held until served or aborted).
- if_addr_in  in  32  fetch address, halfword aligned (bit 0 ignored).
- if_abort_in  in  1  drop current request (redirect).
- instr_ready_out  out  1  combinational; instr_out valid this cycle.
- instr_out  out  32  instruction; upper 16 bits zero for compressed instructions.
- mem_req_out  out  1  line-fill request, level, held until accepted.
- mem_addr_out  out  32  line base address, low LINE_WORD_WIDTH+2 bits zero.
- mem_busy_in  in  1  memory controller busy; request accepted on a cycle with mem_req_out=1 and mem_busy_in=0.
- mem_valid_in  in  1  one fill word delivered.
- mem_data_in  in  32  fill word, delivered in ascending address order.

## Operation
- Address split: tag = [31:SET_WIDTH+LINE_WORD_WIDTH+2], set = next SET_WIDTH bits, halfword offset = [LINE_WORD_WIDTH+1:1].
- Lookup A is at if_addr_in and lookup B is at if_addr_in+2; both are combinational across all ways.
- Compressed hit: A hits and the halfword's [1:0] != 2'b11.
- 32-bit hit: A hits, [1:0] == 2'b11, and B hits. B is in the same line unless the offset is the last halfword, in which case B is in the next line, possibly in another set.
- instr_ready_out = state==IDLE && rdy_in && if_valid_in && !if_abort_in && !flush_in && hit.
- Miss: the target is the line of A if A misses, otherwise the line of B.
  - The victim way is the way with valid=0 at the lowest index; if all ways are valid, use the per-set round-robin counter.
  - The round-robin counter increments on each fill into that set.
- States:
  - IDLE: on miss, latch the target and victim, then go to REQ.
  - REQ: drive mem_req_out=1 and mem_addr_out. On acceptance go to FILL with word count 0.
  - FILL: on each mem_valid_in, write the word into the victim line at the count and increment the count. On the last word, set valid and tag, and return to IDLE.
- Memory data is never bypassed to instr_out. The request is looked up again in IDLE after the fill.
- if_abort_in during REQ or FILL: the fill continues to completion, with no delivery. The line is still installed.
- flush_in: clears all valid bits and round-robin counters at the edge.
  - During FILL it also sets a discard flag. The remaining words are drained, but tag and valid are not written.
  - A flush in the same cycle as the last fill word wins, and the line is not valid.
  - In REQ the request stays outstanding and its data is discarded.

## Timing
- Reset (asynchronous, rst_in=0): state IDLE, all valid bits 0, counters 0, mem_req_out=0, mem_addr_out=0. instr_ready_out and instr_out are 0 because the combinational path is gated by IDLE and valid.
- rdy_in=0: no state, counter or array updates. mem_req_out holds its value. instr_ready_out=0.
- Hit latency is 0 cycles (same cycle as if_valid_in).
- Miss timing:
  - Cycle 0: miss detected.
  - Cycle 1: mem_req_out=1.
  - Accepted at cycle 1+k, where k is the number of busy cycles.
  - Words arrive in later cycles; the line is valid after the edge of the last word.
  - The hit is served in the next cycle.
- A straddling 32-bit instruction with both lines missing takes two sequential fills (A first).
- Deassertion of if_valid_in mid-fill is treated as an abort.

## Structure
- Shared constants go in const_param.v: state encodings (IDLE/REQ/FILL) and default SET_WIDTH, LINE_WORD_WIDTH, WAY_WIDTH.
- Sub-module icache_way holds the valid, tag and data arrays for one way. It has two combinational read ports (A, B) and one word write port plus a tag/valid write. It is instantiated 2^WAY_WIDTH times.
- Top level contains hit/select muxing, victim choice, round-robin counters and the FSM.

## Test plan
- Cold miss on 0x0000_1000, memory words 0x00000013 ×4 → one request with mem_addr_out=0x1000. After the 4th word, the next cycle gives instr_ready_out=1, instr_out=0x00000013. A fetch of 0x1004 hits with no request.
- Compressed: word 0x0001_4501 at 0x2000 → fetch 0x2000 returns 0x00004501 and fetch 0x2002 returns 0x00000001, each with zero latency after the fill.
- Straddle (defaults): 0x3000 line with last word 0x00B3_xxxx, so the halfword at 0x300E is 0x00B3. Then 0x3010 line with first halfword 0x0000. Fetch 0x300E → two fills (0x3000, then 0x3010), then instr_out=0x000000B3.
- Replacement (WAY_WIDTH=1): fill 0x1000, 0x1400 and 0x1800 (same set) → 0x1800 evicts 0x1000. A fetch of 0x1000 misses and 0x1400 still hits.
- Flush on the 3rd fill word of 0x4000 → 4th word accepted, fetch of 0x4000 misses again, and a new request is issued.
- Abort in REQ while mem_busy_in=1 for 3 cycles → request held then accepted, line installed, no instr_ready_out. A later fetch of the same line hits in 0 cycles. Asserting rst_in=0 mid-FILL returns to IDLE with mem_req_out=0 immediately.
